// File: rtl/seeg_cmd_sequencer.sv
// sEEG mode sequencer: command edge detection, record/zcheck/stim FSM and batch strobes.
// Optional DRAIN idle watchdog enabled by defining SEEG_SEQ_DRAIN_WATCHDOG_EN.
module seeg_cmd_sequencer #(
  parameter int BATCH_W        = 16,
  parameter int STIM_W         = 16,
  parameter int ZCHECK_SAMPLES = 1024,
  parameter int DRAIN_TIMEOUT  = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        cmd_reg,
  input  logic [BATCH_W-1:0] batch_size,
  input  logic [STIM_W-1:0]  stim_count,
  input  logic               sample_tick,
  output logic               record_en,
  output logic               zcheck_en,
  output logic               stim_en,
  output logic               batch_last,
  output logic               seq_done,
  output logic               busy,
  output logic [2:0]         state,
  output logic               cmd_err,
  output logic               drain_timeout
);
  localparam int ZC_W = $clog2(ZCHECK_SAMPLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REC      = 3'd1,
    S_DRAIN    = 3'd2,
    S_ZCHK     = 3'd3,
    S_STIM_FIN = 3'd4,
    S_STIM_INF = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        cmd_prev_q;
  logic [BATCH_W-1:0] batch_eff_q, batch_eff_d, batch_cnt_q, batch_cnt_d;
  logic [STIM_W-1:0]  stim_cnt_q, stim_cnt_d;
  logic [ZC_W-1:0]    zc_cnt_q, zc_cnt_d;
  logic               batch_last_q, batch_last_d;
  logic               seq_done_q, seq_done_d;
  logic               cmd_err_q, cmd_err_d;

  logic [31:0] rise;
  logic [5:0]  cmd_vec, legal, cand, win;
  logic        unused_rise;

  assign rise        = cmd_reg & ~cmd_prev_q;
  assign unused_rise = ^{rise[30:9], rise[5:3]};
  // Index 0 is the highest same-cycle priority.
  assign cmd_vec = {rise[7], rise[6], rise[2], rise[0], rise[1], rise[8]};

`ifdef SEEG_SEQ_DRAIN_WATCHDOG_EN
  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              dto_q, dto_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      dto_q      <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      dto_q      <= dto_d;
    end
  end
  assign drain_timeout = dto_q;
`else
  localparam int unused_drain_timeout = DRAIN_TIMEOUT;
  assign drain_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_prev_q   <= '1;
      batch_eff_q  <= BATCH_W'(1);
      batch_cnt_q  <= '0;
      stim_cnt_q   <= '0;
      zc_cnt_q     <= '0;
      batch_last_q <= 1'b0;
      seq_done_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_prev_q   <= cmd_reg;
      batch_eff_q  <= batch_eff_d;
      batch_cnt_q  <= batch_cnt_d;
      stim_cnt_q   <= stim_cnt_d;
      zc_cnt_q     <= zc_cnt_d;
      batch_last_q <= batch_last_d;
      seq_done_q   <= seq_done_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    batch_eff_d  = batch_eff_q;
    batch_cnt_d  = batch_cnt_q;
    stim_cnt_d   = stim_cnt_q;
    zc_cnt_d     = zc_cnt_q;
    batch_last_d = 1'b0;
    seq_done_d   = 1'b0;
    cmd_err_d    = cmd_err_q;
`ifdef SEEG_SEQ_DRAIN_WATCHDOG_EN
    idle_cnt_d   = '0;
    dto_d        = dto_q;
`endif
    if (rise[31]) begin
      cmd_err_d = 1'b0;
`ifdef SEEG_SEQ_DRAIN_WATCHDOG_EN
      dto_d     = 1'b0;
`endif
    end

    // The sample tick is consumed first; any command then acts on the post-tick state.
    if (sample_tick) begin
      case (state_q)
        S_REC, S_DRAIN: begin
          if (batch_cnt_q == batch_eff_q - BATCH_W'(1)) begin
            batch_cnt_d  = '0;
            batch_last_d = 1'b1;
            if (state_q == S_DRAIN) begin
              state_d    = S_IDLE;
              seq_done_d = 1'b1;
            end
          end else begin
            batch_cnt_d = batch_cnt_q + BATCH_W'(1);
          end
        end
        S_ZCHK: begin
          if (zc_cnt_q == ZC_W'(ZCHECK_SAMPLES - 1)) begin
            state_d    = S_IDLE;
            seq_done_d = 1'b1;
          end else begin
            zc_cnt_d = zc_cnt_q + ZC_W'(1);
          end
        end
        S_STIM_FIN: begin
          if (stim_cnt_q <= STIM_W'(1)) begin
            stim_cnt_d = '0;
            state_d    = S_IDLE;
            seq_done_d = 1'b1;
          end else begin
            stim_cnt_d = stim_cnt_q - STIM_W'(1);
          end
        end
        default: ;
      endcase
    end

`ifdef SEEG_SEQ_DRAIN_WATCHDOG_EN
    if (state_q == S_DRAIN && state_d == S_DRAIN) begin
      if (sample_tick) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == IDLE_W'(DRAIN_TIMEOUT - 1)) begin
        state_d = S_IDLE;
        dto_d   = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end
`endif

    legal[0] = (state_d == S_STIM_INF);
    legal[1] = (state_d == S_REC) || (state_d == S_ZCHK);
    legal[2] = (state_d == S_IDLE);
    legal[3] = (state_d == S_IDLE);
    legal[4] = (state_d == S_IDLE) && (stim_count != '0);
    legal[5] = (state_d == S_IDLE);
    cand     = cmd_vec & legal;
    win      = cand & (~cand + 6'd1);
    if ((cmd_vec & ~win) != 6'd0) cmd_err_d = 1'b1;

    if (win[0]) begin
      state_d = S_IDLE;
    end else if (win[1]) begin
      state_d = (state_d == S_REC && batch_cnt_d != '0) ? S_DRAIN : S_IDLE;
    end else if (win[2]) begin
      batch_eff_d = (batch_size == '0) ? BATCH_W'(1) : batch_size;
      batch_cnt_d = '0;
      state_d     = S_REC;
    end else if (win[3]) begin
      zc_cnt_d = '0;
      state_d  = S_ZCHK;
    end else if (win[4]) begin
      stim_cnt_d = stim_count;
      state_d    = S_STIM_FIN;
    end else if (win[5]) begin
      state_d = S_STIM_INF;
    end
  end

  assign state      = state_q;
  assign busy       = (state_q != S_IDLE);
  assign record_en  = (state_q == S_REC) || (state_q == S_DRAIN);
  assign zcheck_en  = (state_q == S_ZCHK);
  assign stim_en    = (state_q == S_STIM_FIN) || (state_q == S_STIM_INF);
  assign batch_last = batch_last_q;
  assign seq_done   = seq_done_q;
  assign cmd_err    = cmd_err_q;
endmodule

// File: tb/tb_seeg_cmd_sequencer.sv
// Testbench for seeg_cmd_sequencer: scenario tasks with randomized stimulus and arithmetic expectations.
module tb_seeg_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd_reg = '0;
  logic [15:0] batch_size = '0;
  logic [15:0] stim_count = '0;
  logic        sample_tick = 1'b0;
  logic        record_en, zcheck_en, stim_en, batch_last, seq_done, busy, cmd_err, drain_timeout;
  logic [2:0]  state;
  int          total = 0;
  int          bad = 0;

  seeg_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_reg(cmd_reg), .batch_size(batch_size), .stim_count(stim_count),
    .sample_tick(sample_tick), .record_en(record_en), .zcheck_en(zcheck_en), .stim_en(stim_en),
    .batch_last(batch_last), .seq_done(seq_done), .busy(busy), .state(state),
    .cmd_err(cmd_err), .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, required completion within 5ms");
    $fatal(1, "timeout");
  end

  // One clock: drive inputs, let the edge happen, leave outputs ready to sample 1ns later.
  task automatic step(input logic [31:0] c, input logic t);
    cmd_reg = c;
    sample_tick = t;
    @(posedge clk);
    #1;
    cmd_reg = '0;
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    step(0, 0);
  endtask

  task automatic test_reset();
    repeat (3) begin cmd_reg = 32'h1; @(posedge clk); #1; end
    total++;
    if ({record_en, zcheck_en, stim_en, batch_last, seq_done, busy, cmd_err, drain_timeout} !== 8'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs: got state=%0d flags=%b, required state=0 flags=00000000", state,
               {record_en, zcheck_en, stim_en, batch_last, seq_done, busy, cmd_err, drain_timeout});
    end
    rst = 1'b0;
    repeat (3) begin cmd_reg = 32'h1; @(posedge clk); #1; end
    total++;
    if (state !== 3'd0 || record_en !== 1'b0) begin
      bad++; $display("FAIL held_cmd_ignored: got state=%0d record_en=%b, required 0 0", state, record_en);
    end
    batch_size = 16'd0;
    step(0, 0);
    step(32'h1, 0);
    total++;
    if (state !== 3'd1 || record_en !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL rerise_start: got state=%0d rec=%b busy=%b, required 1 1 1", state, record_en, busy);
    end
    rst = 1'b1;
    step(0, 1);
    rst = 1'b0;
    total++;
    if (state !== 3'd0 || batch_last !== 1'b0 || seq_done !== 1'b0 || record_en !== 1'b0) begin
      bad++; $display("FAIL reset_midop: got state=%0d bl=%b sd=%b rec=%b, required 0 0 0 0", state, batch_last, seq_done, record_en);
    end
    step(0, 0);
    $display("reset scenario done");
  endtask

  task automatic test_record(input int b, input int n);
    int beff, drain_end;
    logic exp_bl;
    beff = (b == 0) ? 1 : b;
    batch_size = b[15:0];
    step(32'h1, 0);
    total++;
    if (state !== 3'd1 || record_en !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL rec_start: got state=%0d rec=%b busy=%b, required 1 1 1", state, record_en, busy);
    end
    for (int i = 1; i <= n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        step(0, 0);
        total++;
        if (batch_last !== 1'b0 || record_en !== 1'b1 || state !== 3'd1) begin
          bad++; $display("FAIL rec_gap: got bl=%b rec=%b state=%0d, required 0 1 1", batch_last, record_en, state);
        end
      end
      step(0, 1);
      exp_bl = (i % beff == 0);
      total++;
      if (batch_last !== exp_bl || record_en !== 1'b1 || seq_done !== 1'b0 || state !== 3'd1) begin
        bad++; $display("FAIL rec_tick %0d: got bl=%b rec=%b sd=%b state=%0d, required bl=%b 1 0 1", i, batch_last, record_en, seq_done, state, exp_bl);
      end
    end
    batch_size = 16'($urandom);
    step(32'h2, 0);
    if (n % beff == 0) begin
      total++;
      if (state !== 3'd0 || record_en !== 1'b0 || seq_done !== 1'b0) begin
        bad++; $display("FAIL rec_stop_direct: got state=%0d rec=%b sd=%b, required 0 0 0", state, record_en, seq_done);
      end
    end else begin
      total++;
      if (state !== 3'd2 || record_en !== 1'b1) begin
        bad++; $display("FAIL rec_stop_drain: got state=%0d rec=%b, required 2 1", state, record_en);
      end
      drain_end = ((n / beff) + 1) * beff;
      for (int i = n + 1; i <= drain_end; i++) begin
        step(0, 1);
        total++;
        if (i == drain_end) begin
          if (batch_last !== 1'b1 || seq_done !== 1'b1 || state !== 3'd0 || record_en !== 1'b0) begin
            bad++; $display("FAIL drain_end tick %0d: got bl=%b sd=%b state=%0d rec=%b, required 1 1 0 0", i, batch_last, seq_done, state, record_en);
          end
        end else if (batch_last !== 1'b0 || seq_done !== 1'b0 || state !== 3'd2 || record_en !== 1'b1) begin
          bad++; $display("FAIL drain_tick %0d: got bl=%b sd=%b state=%0d rec=%b, required 0 0 2 1", i, batch_last, seq_done, state, record_en);
        end
      end
    end
    step(0, 0);
    total++;
    if (seq_done !== 1'b0 || batch_last !== 1'b0 || state !== 3'd0 || cmd_err !== 1'b0) begin
      bad++; $display("FAIL rec_after: got sd=%b bl=%b state=%0d err=%b, required 0 0 0 0", seq_done, batch_last, state, cmd_err);
    end
    $display("record batch_size=%0d ticks=%0d done", b, n);
  endtask

  task automatic test_stop_with_tick(input int b, input int k);
    batch_size = b[15:0];
    step(32'h1, 0);
    for (int i = 1; i < k; i++) step(0, 1);
    step(32'h2, 1);
    total++;
    if (k == b) begin
      if (state !== 3'd0 || batch_last !== 1'b1 || seq_done !== 1'b0 || record_en !== 1'b0) begin
        bad++; $display("FAIL stop_on_wrap: got state=%0d bl=%b sd=%b rec=%b, required 0 1 0 0", state, batch_last, seq_done, record_en);
      end
    end else begin
      if (state !== 3'd2 || batch_last !== 1'b0 || record_en !== 1'b1) begin
        bad++; $display("FAIL stop_with_tick: got state=%0d bl=%b rec=%b, required 2 0 1", state, batch_last, record_en);
      end
      for (int i = k + 1; i <= b; i++) step(0, 1);
      total++;
      if (state !== 3'd0 || batch_last !== 1'b1 || seq_done !== 1'b1) begin
        bad++; $display("FAIL stop_with_tick_drain: got state=%0d bl=%b sd=%b, required 0 1 1", state, batch_last, seq_done);
      end
    end
    step(0, 0);
    $display("stop with tick batch_size=%0d at tick %0d done", b, k);
  endtask

  task automatic test_zcheck(input int abort_at);
    step(32'h4, 0);
    total++;
    if (state !== 3'd3 || zcheck_en !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL zchk_start: got state=%0d zc=%b busy=%b, required 3 1 1", state, zcheck_en, busy);
    end
    for (int i = 1; i <= 1024; i++) begin
      step(0, 1);
      total++;
      if (i < 1024) begin
        if (zcheck_en !== 1'b1 || seq_done !== 1'b0 || state !== 3'd3) begin
          bad++; $display("FAIL zchk_tick %0d: got zc=%b sd=%b state=%0d, required 1 0 3", i, zcheck_en, seq_done, state);
        end
      end else if (zcheck_en !== 1'b0 || seq_done !== 1'b1 || state !== 3'd0) begin
        bad++; $display("FAIL zchk_end: got zc=%b sd=%b state=%0d, required 0 1 0", zcheck_en, seq_done, state);
      end
    end
    step(0, 0);
    step(32'h4, 0);
    for (int i = 1; i <= abort_at; i++) step(0, 1);
    step(32'h2, 0);
    total++;
    if (state !== 3'd0 || zcheck_en !== 1'b0 || seq_done !== 1'b0 || cmd_err !== 1'b0) begin
      bad++; $display("FAIL zchk_abort: got state=%0d zc=%b sd=%b err=%b, required 0 0 0 0", state, zcheck_en, seq_done, cmd_err);
    end
    step(0, 0);
    $display("zcheck full run and abort at tick %0d done", abort_at);
  endtask

  task automatic test_stim_finite(input int c);
    stim_count = c[15:0];
    step(32'h40, 0);
    stim_count = 16'($urandom);
    total++;
    if (state !== 3'd4 || stim_en !== 1'b1) begin
      bad++; $display("FAIL stim_fin_start: got state=%0d stim=%b, required 4 1", state, stim_en);
    end
    for (int i = 1; i <= c; i++) begin
      repeat ($urandom_range(0, 2)) step(0, 0);
      step(0, 1);
      total++;
      if (i < c) begin
        if (stim_en !== 1'b1 || seq_done !== 1'b0) begin
          bad++; $display("FAIL stim_fin_tick %0d: got stim=%b sd=%b, required 1 0", i, stim_en, seq_done);
        end
      end else if (stim_en !== 1'b0 || seq_done !== 1'b1 || state !== 3'd0) begin
        bad++; $display("FAIL stim_fin_end: got stim=%b sd=%b state=%0d, required 0 1 0", stim_en, seq_done, state);
      end
    end
    step(0, 0);
    total++;
    if (seq_done !== 1'b0 || cmd_err !== 1'b0) begin
      bad++; $display("FAIL stim_fin_after: got sd=%b err=%b, required 0 0", seq_done, cmd_err);
    end
    $display("finite stim count=%0d done", c);
  endtask

  task automatic test_stim_zero();
    stim_count = 16'd0;
    step(32'h40, 0);
    total++;
    if (cmd_err !== 1'b1 || state !== 3'd0 || stim_en !== 1'b0) begin
      bad++; $display("FAIL stim_zero: got err=%b state=%0d stim=%b, required 1 0 0", cmd_err, state, stim_en);
    end
    step(32'h8000_0000, 0);
    total++;
    if (cmd_err !== 1'b0) begin
      bad++; $display("FAIL stim_zero_clear: got err=%b, required 0", cmd_err);
    end
    $display("finite stim with zero count done");
  endtask

  task automatic test_stim_infinite();
    step(32'h80, 0);
    total++;
    if (state !== 3'd5 || stim_en !== 1'b1) begin
      bad++; $display("FAIL stim_inf_start: got state=%0d stim=%b, required 5 1", state, stim_en);
    end
    for (int i = 1; i <= 500; i++) begin
      step(0, 1);
      total++;
      if (stim_en !== 1'b1 || seq_done !== 1'b0 || state !== 3'd5) begin
        bad++; $display("FAIL stim_inf_tick %0d: got stim=%b sd=%b state=%0d, required 1 0 5", i, stim_en, seq_done, state);
      end
    end
    step(32'h100, 0);
    total++;
    if (state !== 3'd0 || stim_en !== 1'b0 || seq_done !== 1'b0 || cmd_err !== 1'b0) begin
      bad++; $display("FAIL stim_inf_stop: got state=%0d stim=%b sd=%b err=%b, required 0 0 0 0", state, stim_en, seq_done, cmd_err);
    end
    step(0, 0);
    $display("infinite stim 500 ticks done");
  endtask

  task automatic test_conflicts();
    batch_size = 16'd7;
    step(32'h5, 0);
    total++;
    if (state !== 3'd1 || cmd_err !== 1'b1) begin
      bad++; $display("FAIL conflict_rec_zchk: got state=%0d err=%b, required 1 1", state, cmd_err);
    end
    step(32'h8000_0000, 0);
    total++;
    if (state !== 3'd1 || cmd_err !== 1'b0) begin
      bad++; $display("FAIL conflict_clear: got state=%0d err=%b, required 1 0", state, cmd_err);
    end
    step(32'h4, 0);
    total++;
    if (state !== 3'd1 || cmd_err !== 1'b1) begin
      bad++; $display("FAIL zchk_in_rec: got state=%0d err=%b, required 1 1", state, cmd_err);
    end
    step(32'h8000_0000, 0);
    step(32'h1, 0);
    total++;
    if (state !== 3'd1 || cmd_err !== 1'b1) begin
      bad++; $display("FAIL rec_in_rec: got state=%0d err=%b, required 1 1", state, cmd_err);
    end
    step(32'h8000_0000, 0);
    step(32'h2, 0);
    total++;
    if (state !== 3'd0 || cmd_err !== 1'b0 || seq_done !== 1'b0) begin
      bad++; $display("FAIL stop_empty_rec: got state=%0d err=%b sd=%b, required 0 0 0", state, cmd_err, seq_done);
    end
    step(32'h8000_0001, 0);
    total++;
    if (state !== 3'd1 || cmd_err !== 1'b0) begin
      bad++; $display("FAIL clear_with_start: got state=%0d err=%b, required 1 0", state, cmd_err);
    end
    step(32'h2, 0);
    step(0, 0);
    $display("conflict scenario done");
  endtask

  task automatic test_random_cmds(input int iters);
    int m, sc, won;
    logic [2:0] mode_code, exp_state;
    logic [31:0] bits;
    logic exp_err;
    for (int it = 0; it < iters; it++) begin
      do_reset();
      m = $urandom_range(0, 4);
      batch_size = 16'd9;
      stim_count = 16'd5;
      case (m)
        1: begin step(32'h1, 0); mode_code = 3'd1; end
        2: begin step(32'h4, 0); mode_code = 3'd3; end
        3: begin step(32'h40, 0); mode_code = 3'd4; end
        4: begin step(32'h80, 0); mode_code = 3'd5; end
        default: mode_code = 3'd0;
      endcase
      step(0, 0);
      bits = $urandom & 32'h1C7;
      sc = $urandom_range(0, 3);
      stim_count = sc[15:0];
      exp_state = mode_code;
      won = 0;
      case (mode_code)
        3'd0: begin
          if (bits[0]) exp_state = 3'd1;
          else if (bits[2]) exp_state = 3'd3;
          else if (bits[6] && sc != 0) exp_state = 3'd4;
          else if (bits[7]) exp_state = 3'd5;
          won = (exp_state != 3'd0) ? 1 : 0;
        end
        3'd1, 3'd3: if (bits[1]) begin exp_state = 3'd0; won = 1; end
        3'd5: if (bits[8]) begin exp_state = 3'd0; won = 1; end
        default: ;
      endcase
      exp_err = ($countones(bits) != won);
      step(bits, 0);
      total++;
      if (state !== exp_state || cmd_err !== exp_err || seq_done !== 1'b0 ||
          record_en !== (exp_state == 3'd1) || zcheck_en !== (exp_state == 3'd3) ||
          stim_en !== (exp_state == 3'd4 || exp_state == 3'd5)) begin
        bad++; $display("FAIL random_cmd: mode=%0d bits=%h sc=%0d got state=%0d err=%b sd=%b, required state=%0d err=%b sd=0",
                        mode_code, bits, sc, state, cmd_err, seq_done, exp_state, exp_err);
      end
      $display("random cmd mode=%0d bits=%h stim_count=%0d -> state=%0d err=%b", mode_code, bits, sc, state, cmd_err);
    end
    do_reset();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_record(41, 100);
    test_record(0, 12);
    repeat (4) test_record($urandom_range(1, 30), $urandom_range(1, 80));
    test_stop_with_tick(5, 5);
    repeat (4) begin
      int b;
      b = $urandom_range(2, 10);
      test_stop_with_tick(b, $urandom_range(1, b));
    end
    test_zcheck(10);
    test_zcheck($urandom_range(1, 1023));
    test_stim_finite(8);
    repeat (3) test_stim_finite($urandom_range(1, 20));
    test_stim_zero();
    test_stim_infinite();
    test_conflicts();
    test_random_cmds(25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
